// File: rtl/axi_pkg.sv
// AXI request/response bundles shared by the arbiter, its masters and the
// downstream port. Each channel is a packed struct so a whole port can be
// zeroed or muxed in one assignment.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_LEN_W  = 8;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [AXI_LEN_W-1:0]  awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
    } axi_aw_req_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
    } axi_w_req_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] araddr;
        logic [AXI_LEN_W-1:0]  arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
    } axi_ar_req_t;

    typedef struct packed {
        logic bready;
    } axi_b_req_t;

    typedef struct packed {
        logic rready;
    } axi_r_req_t;

    typedef struct packed {
        axi_aw_req_t aw;
        axi_w_req_t  w;
        axi_ar_req_t ar;
        axi_b_req_t  b;
        axi_r_req_t  r;
    } axi_request_t;

    typedef struct packed {
        logic awready;
    } axi_aw_rsp_t;

    typedef struct packed {
        logic wready;
    } axi_w_rsp_t;

    typedef struct packed {
        logic arready;
    } axi_ar_rsp_t;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } axi_b_rsp_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rvalid;
    } axi_r_rsp_t;

    typedef struct packed {
        axi_aw_rsp_t aw;
        axi_w_rsp_t  w;
        axi_ar_rsp_t ar;
        axi_b_rsp_t  b;
        axi_r_rsp_t  r;
    } axi_response_t;

    localparam axi_request_t  AXI_REQ_IDLE = '0;
    localparam axi_response_t AXI_RSP_IDLE = '0;

endpackage

// File: rtl/axi_rr_pick2.sv
// Two-way requester picker. A lone requester always wins; on contention the
// master that did not win last time wins, unless fixed priority pins it to m0.
// 'last' is the index of the previous winner (0 = m0, 1 = m1).
module axi_rr_pick2 (
    input  logic [1:0] pending,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] pick
);

    // One-hot pick from the pending vector
    always_comb begin
        pick = 2'b00;
        case (pending)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (fixed || last) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_arbiter_2x1.sv
// Two-master AXI arbiter: one whole transaction (address, all beats, write
// response) is owned by one master at a time. Routing is purely combinational
// from the registered state, so handshakes pass through with no added cycles.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no owner; sample pending masters and pick one
//   RD_ADDR | forward granted AR until arready handshake
//   RD_DATA | forward R beats; beat count decides the last one
//   WR_ADDR | forward granted AW; W held back until AW completes
//   WR_DATA | forward W beats; wlast regenerated from the count
//   WR_RESP | forward B until bvalid & bready
module axi_arbiter_2x1 import axi_pkg::*; #(
    parameter bit WRITE_FIRST    = 1'b1,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  axi_request_t  m0_req_i,
    output axi_response_t m0_rsp_o,
    input  axi_request_t  m1_req_i,
    output axi_response_t m1_rsp_o,
    output axi_request_t  s_req_o,
    input  axi_response_t s_rsp_i,
    output logic [1:0]    grant_o,
    output logic          busy_o,
    output logic          wlast_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } arb_state_t;

    arb_state_t           state_q;
    logic [1:0]           gnt_q;
    logic                 last_q;
    logic [AXI_LEN_W-1:0] beats_q;
    logic                 wlast_err_q;

    logic [1:0]    pending;
    logic [1:0]    pick;
    axi_request_t  pick_req;
    axi_request_t  sel_req;
    axi_response_t rsp_sel;
    logic          beat_last;
    logic          ar_hs;
    logic          r_hs;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;

    assign pending[0] = m0_req_i.aw.awvalid | m0_req_i.ar.arvalid;
    assign pending[1] = m1_req_i.aw.awvalid | m1_req_i.ar.arvalid;

    axi_rr_pick2 u_pick (
        .pending (pending),
        .last    (last_q),
        .fixed   (FIXED_PRIORITY),
        .pick    (pick)
    );

    assign pick_req  = pick[1]  ? m1_req_i : m0_req_i;
    assign sel_req   = gnt_q[1] ? m1_req_i : m0_req_i;
    assign beat_last = (beats_q == '0);

    assign ar_hs = sel_req.ar.arvalid & s_rsp_i.ar.arready;
    assign r_hs  = s_rsp_i.r.rvalid   & sel_req.r.rready;
    assign aw_hs = sel_req.aw.awvalid & s_rsp_i.aw.awready;
    assign w_hs  = sel_req.w.wvalid   & s_rsp_i.w.wready;
    assign b_hs  = s_rsp_i.b.bvalid   & sel_req.b.bready;

    // Transaction sequencer: grant, burst down-counter, wlast mismatch pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            last_q      <= 1'b1;
            beats_q     <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            wlast_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick != 2'b00) begin
                        gnt_q  <= pick;
                        last_q <= pick[1];
                        if (pick_req.aw.awvalid && (WRITE_FIRST || !pick_req.ar.arvalid))
                            state_q <= WR_ADDR;
                        else
                            state_q <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        beats_q <= sel_req.ar.arlen;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        if (beat_last) begin
                            state_q <= IDLE;
                            gnt_q   <= 2'b00;
                        end else begin
                            beats_q <= beats_q - 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (aw_hs) begin
                        beats_q <= sel_req.aw.awlen;
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (sel_req.w.wlast != beat_last)
                            wlast_err_q <= 1'b1;
                        if (beat_last)
                            state_q <= WR_RESP;
                        else
                            beats_q <= beats_q - 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Open only the channel that belongs to the current state; all else is zero
    always_comb begin
        s_req_o = AXI_REQ_IDLE;
        rsp_sel = AXI_RSP_IDLE;
        case (state_q)
            RD_ADDR: begin
                s_req_o.ar = sel_req.ar;
                rsp_sel.ar = s_rsp_i.ar;
            end
            RD_DATA: begin
                s_req_o.r = sel_req.r;
                rsp_sel.r = s_rsp_i.r;
            end
            WR_ADDR: begin
                s_req_o.aw = sel_req.aw;
                rsp_sel.aw = s_rsp_i.aw;
            end
            WR_DATA: begin
                s_req_o.w       = sel_req.w;
                s_req_o.w.wlast = beat_last;
                rsp_sel.w       = s_rsp_i.w;
            end
            WR_RESP: begin
                s_req_o.b = sel_req.b;
                rsp_sel.b = s_rsp_i.b;
            end
            default: begin
            end
        endcase
    end

    assign m0_rsp_o    = gnt_q[0] ? rsp_sel : AXI_RSP_IDLE;
    assign m1_rsp_o    = gnt_q[1] ? rsp_sel : AXI_RSP_IDLE;
    assign grant_o     = gnt_q;
    assign busy_o      = (state_q != IDLE);
    assign wlast_err_o = wlast_err_q;

endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// Directed bench for the 2x1 AXI arbiter. Expected beats and grants are queued
// when stimulus is driven and popped by a negedge monitor as the DUT emits them.
module tb_axi_arbiter_2x1;
    import axi_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    axi_request_t  m0_req;
    axi_request_t  m1_req;
    axi_request_t  s_req;
    axi_response_t m0_rsp;
    axi_response_t m1_rsp;
    axi_response_t s_rsp;
    logic [1:0]    grant;
    logic          busy;
    logic          wlast_err;

    int total   = 0;
    int bad     = 0;
    int err_cnt = 0;

    logic [63:0] exp_w[$];
    logic [63:0] exp_r0[$];
    logic [63:0] exp_r1[$];
    logic [1:0]  exp_gnt[$];
    logic [1:0]  prev_gnt = 2'b00;

    always #5 clk = ~clk;

    axi_arbiter_2x1 dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req_i    (m0_req),
        .m0_rsp_o    (m0_rsp),
        .m1_req_i    (m1_req),
        .m1_rsp_o    (m1_rsp),
        .s_req_o     (s_req),
        .s_rsp_i     (s_rsp),
        .grant_o     (grant),
        .busy_o      (busy),
        .wlast_err_o (wlast_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(input bit mst, input axi_request_t r);
        if (mst) m1_req = r;
        else     m0_req = r;
    endtask

    function automatic axi_request_t get_req(input bit mst);
        return mst ? m1_req : m0_req;
    endfunction

    function automatic axi_response_t get_rsp(input bit mst);
        return mst ? m1_rsp : m0_rsp;
    endfunction

    // which: 0 = downstream awvalid, 1 = downstream arvalid
    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (((which == 0) ? !s_req.aw.awvalid : !s_req.ar.arvalid) && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 64'(n < 20), 64'd1);
    endtask

    task automatic run_read(input bit mst, input int len, input logic [31:0] addr,
                            input logic [31:0] dbase, input int delay);
        axi_request_t  r;
        axi_response_t q;
        r = get_req(mst);
        r.ar.araddr  = addr;
        r.ar.arlen   = 8'(len);
        r.ar.arsize  = 3'd2;
        r.ar.arburst = 2'b01;
        r.ar.arvalid = 1'b1;
        r.r.rready   = 1'b1;
        put_req(mst, r);
        exp_gnt.push_back(mst ? 2'b10 : 2'b01);
        wait_for(1, "rd_ar_grant");
        chk("rd_ar_addr", 64'(s_req.ar.araddr), 64'(addr));
        chk("rd_ar_len", 64'(s_req.ar.arlen), 64'(len));
        chk("rd_busy", 64'(busy), 64'd1);
        repeat (delay) cyc();
        s_rsp.ar.arready = 1'b1;
        #1;
        q = get_rsp(mst);
        chk("rd_arready_route", 64'(q.ar.arready), 64'd1);
        cyc();
        s_rsp.ar.arready = 1'b0;
        r.ar.arvalid = 1'b0;
        put_req(mst, r);
        for (int i = 0; i <= len; i++) begin
            s_rsp.r.rdata  = dbase + 32'(i);
            s_rsp.r.rresp  = 2'b00;
            s_rsp.r.rvalid = 1'b1;
            if (mst) exp_r1.push_back(64'(dbase + 32'(i)));
            else     exp_r0.push_back(64'(dbase + 32'(i)));
            cyc();
        end
        s_rsp.r.rvalid = 1'b0;
        r.r.rready = 1'b0;
        put_req(mst, r);
    endtask

    task automatic run_write(input bit mst, input int len, input logic [31:0] dat[4],
                             input int bad_beat);
        axi_request_t  r;
        axi_response_t q;
        r = get_req(mst);
        r.aw.awaddr  = 32'h0000_2000;
        r.aw.awlen   = 8'(len);
        r.aw.awsize  = 3'd2;
        r.aw.awburst = 2'b01;
        r.aw.awvalid = 1'b1;
        r.w.wdata    = dat[0];
        r.w.wstrb    = 4'hF;
        r.w.wlast    = 1'b0;
        r.w.wvalid   = 1'b1;
        r.b.bready   = 1'b1;
        put_req(mst, r);
        exp_gnt.push_back(mst ? 2'b10 : 2'b01);
        wait_for(0, "wr_aw_grant");
        chk("wr_w_held_before_aw", 64'(s_req.w.wvalid), 64'd0);
        chk("wr_ar_quiet", 64'(s_req.ar.arvalid), 64'd0);
        s_rsp.aw.awready = 1'b1;
        #1;
        q = get_rsp(mst);
        chk("wr_awready_route", 64'(q.aw.awready), 64'd1);
        cyc();
        s_rsp.aw.awready = 1'b0;
        r.aw.awvalid = 1'b0;
        put_req(mst, r);
        s_rsp.w.wready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            r.w.wdata = dat[i];
            r.w.wlast = (bad_beat >= 0) ? (i == bad_beat) : (i == len);
            put_req(mst, r);
            exp_w.push_back(64'({dat[i], (i == len)}));
            cyc();
        end
        r.w.wvalid = 1'b0;
        r.w.wlast  = 1'b0;
        put_req(mst, r);
        s_rsp.w.wready = 1'b0;
        s_rsp.b.bresp  = 2'b00;
        s_rsp.b.bvalid = 1'b1;
        #1;
        q = get_rsp(mst);
        chk("wr_bvalid_route", 64'(q.b.bvalid), 64'd1);
        chk("wr_bready_route", 64'(s_req.b.bready), 64'd1);
        cyc();
        s_rsp.b.bvalid = 1'b0;
        r.b.bready = 1'b0;
        put_req(mst, r);
    endtask

    // Monitor: scoreboard pops, grant order, isolation, wlast error pulses
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (s_req.w.wvalid && s_rsp.w.wready) begin
                    chk("w_beat_expected", 64'(exp_w.size() != 0), 64'd1);
                    if (exp_w.size() != 0) begin
                        e = exp_w.pop_front();
                        chk("w_beat", 64'({s_req.w.wdata, s_req.w.wlast}), e);
                    end
                end
                if (m0_rsp.r.rvalid && m0_req.r.rready) begin
                    chk("r0_beat_expected", 64'(exp_r0.size() != 0), 64'd1);
                    if (exp_r0.size() != 0) begin
                        e = exp_r0.pop_front();
                        chk("r0_beat", 64'(m0_rsp.r.rdata), e);
                    end
                end
                if (m1_rsp.r.rvalid && m1_req.r.rready) begin
                    chk("r1_beat_expected", 64'(exp_r1.size() != 0), 64'd1);
                    if (exp_r1.size() != 0) begin
                        e = exp_r1.pop_front();
                        chk("r1_beat", 64'(m1_rsp.r.rdata), e);
                    end
                end
                if (grant != 2'b00 && prev_gnt == 2'b00) begin
                    chk("grant_expected", 64'(exp_gnt.size() != 0), 64'd1);
                    if (exp_gnt.size() != 0)
                        chk("grant_order", 64'(grant), 64'(exp_gnt.pop_front()));
                end
                if (wlast_err) err_cnt++;
                chk("m0_isolated", 64'(grant == 2'b01 || m0_rsp === AXI_RSP_IDLE), 64'd1);
                chk("m1_isolated", 64'(grant == 2'b10 || m1_rsp === AXI_RSP_IDLE), 64'd1);
            end
            prev_gnt = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        axi_request_t r;
        logic [31:0]  wd[4];

        m0_req = '0;
        m1_req = '0;
        s_rsp  = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_req", 64'(s_req === AXI_REQ_IDLE), 64'd1);
        chk("rst_m0_rsp", 64'(m0_rsp === AXI_RSP_IDLE), 64'd1);
        chk("rst_m1_rsp", 64'(m1_rsp === AXI_RSP_IDLE), 64'd1);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // m0 4-beat read, arready two cycles late
        run_read(1'b0, 3, 32'h0000_0100, 32'hA000_0000, 2);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_grant_after", 64'(grant), 64'd0);
        chk("t1_r0_drained", 64'(exp_r0.size()), 64'd0);

        // Contention from reset, both masters re-requesting continuously
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_gnt.push_back(2'b01);
        exp_gnt.push_back(2'b10);
        exp_gnt.push_back(2'b01);
        r = '0;
        r.ar.arlen = 8'd0; r.ar.arsize = 3'd2; r.ar.arburst = 2'b01; r.ar.arvalid = 1'b1;
        r.r.rready = 1'b1;
        r.ar.araddr = 32'h0000_0300;
        m0_req = r;
        r.ar.araddr = 32'h0000_0400;
        m1_req = r;
        #1;
        chk("t2_no_grant_same_cycle", 64'(grant), 64'd0);
        cyc();
        chk("t2_grant_latency", 64'(grant), 64'd1);
        for (int k = 0; k < 3; k++) begin
            wait_for(1, "t2_ar_grant");
            chk("t2_ar_addr", 64'(s_req.ar.araddr), (k == 1) ? 64'h400 : 64'h300);
            s_rsp.ar.arready = 1'b1;
            cyc();
            s_rsp.ar.arready = 1'b0;
            s_rsp.r.rdata  = 32'hB000_0000 + 32'(k);
            s_rsp.r.rvalid = 1'b1;
            if (k == 1) exp_r1.push_back(64'(32'hB000_0000 + 32'(k)));
            else        exp_r0.push_back(64'(32'hB000_0000 + 32'(k)));
            cyc();
            s_rsp.r.rvalid = 1'b0;
        end
        m0_req = '0;
        m1_req = '0;
        cyc();
        cyc();
        chk("t2_busy_after", 64'(busy), 64'd0);
        chk("t2_grants_drained", 64'(exp_gnt.size()), 64'd0);

        // m1 two-beat write
        err_cnt = 0;
        wd[0] = 32'hDEAD_BEEF; wd[1] = 32'h1234_5678; wd[2] = 32'h0; wd[3] = 32'h0;
        run_write(1'b1, 1, wd, -1);
        chk("t3_busy_after", 64'(busy), 64'd0);
        chk("t3_w_drained", 64'(exp_w.size()), 64'd0);
        chk("t3_no_wlast_err", 64'(err_cnt), 64'd0);

        // m1 three-beat write with master wlast on beat 2
        err_cnt = 0;
        wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0001; wd[2] = 32'h3333_0002;
        run_write(1'b1, 2, wd, 1);
        cyc();
        chk("t4_wlast_err_pulses", 64'(err_cnt), 64'd2);
        chk("t4_w_drained", 64'(exp_w.size()), 64'd0);

        // m0 with both aw and ar: write served first, then the read
        err_cnt = 0;
        r = m0_req;
        r.ar.araddr = 32'h0000_0500; r.ar.arlen = 8'd1; r.ar.arsize = 3'd2;
        r.ar.arburst = 2'b01; r.ar.arvalid = 1'b1; r.r.rready = 1'b1;
        m0_req = r;
        wd[0] = 32'h5555_AAAA;
        run_write(1'b0, 0, wd, -1);
        chk("t5_write_done_first", 64'(exp_w.size()), 64'd0);
        chk("t5_idle_between", 64'(busy), 64'd0);
        run_read(1'b0, 1, 32'h0000_0500, 32'hC500_0000, 0);
        chk("t5_r0_drained", 64'(exp_r0.size()), 64'd0);
        chk("t5_no_wlast_err", 64'(err_cnt), 64'd0);

        // Reset in the middle of a 4-beat read burst
        r = '0;
        r.ar.araddr = 32'h0000_0700; r.ar.arlen = 8'd3; r.ar.arsize = 3'd2;
        r.ar.arburst = 2'b01; r.ar.arvalid = 1'b1; r.r.rready = 1'b1;
        m0_req = r;
        exp_gnt.push_back(2'b01);
        wait_for(1, "t6_ar_grant");
        s_rsp.ar.arready = 1'b1;
        cyc();
        s_rsp.ar.arready = 1'b0;
        r.ar.arvalid = 1'b0;
        m0_req = r;
        s_rsp.r.rdata  = 32'hE000_0000;
        s_rsp.r.rvalid = 1'b1;
        exp_r0.push_back(64'h0000_0000_E000_0000);
        cyc();
        s_rsp.r.rdata = 32'hE000_0001;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_s_req", 64'(s_req === AXI_REQ_IDLE), 64'd1);
        chk("t6_rst_m0_rsp", 64'(m0_rsp === AXI_RSP_IDLE), 64'd1);
        chk("t6_rst_m1_rsp", 64'(m1_rsp === AXI_RSP_IDLE), 64'd1);
        chk("t6_rst_grant", 64'(grant), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_wlast_err", 64'(wlast_err), 64'd0);
        m0_req = '0;
        s_rsp  = '0;
        cyc();
        rst = 1'b0;
        chk("t6_r0_only_first_beat", 64'(exp_r0.size()), 64'd0);
        run_read(1'b1, 1, 32'h0000_0600, 32'hD000_0000, 1);
        chk("t6_busy_after", 64'(busy), 64'd0);
        chk("t6_r1_drained", 64'(exp_r1.size()), 64'd0);
        chk("final_grants_drained", 64'(exp_gnt.size()), 64'd0);
        chk("final_w_drained", 64'(exp_w.size()), 64'd0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
